peak_finder: RTL and testbench

PEAK_FINDER -- requirements
Module: peak_finder

---
 rtl/peak_finder.sv | 111 +++++++++++
 tb/tb_peak_finder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/peak_finder.sv
// peak_finder: circular-neighbour peak detector over framed bins with a small output FIFO.
// Optional macro PEAK_FINDER_COUNT_EN adds peakCount (peaks found in the last completed frame).
module peak_finder #(
  parameter int N = 16,
  parameter int BINS = 24,
  parameter int THRESH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [N-1:0] binIn,
  input  logic binWrite,
  output logic [$clog2(BINS)-1:0] peakIdx,
  output logic signed [N-1:0] peakVal,
  output logic peakValid,
  input  logic peakReady,
  output logic frameDone,
  output logic overflow,
  output logic dropErr
`ifdef PEAK_FINDER_COUNT_EN
  ,output logic [$clog2(BINS+1)-1:0] peakCount
`endif
);
  localparam int IW = $clog2(BINS);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IW-1:0] last_bin = IW'(BINS - 1);
  localparam logic [PW-1:0] last_ptr = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] depth = CW'(FIFO_DEPTH);
  localparam logic signed [N-1:0] thresh = N'(THRESH);
  typedef enum logic [1:0] {COLLECT, WRAP_LAST, WRAP_FIRST} state_t;
  state_t state, state_nx;
  logic [IW-1:0] cnt, eval_idx;
  logic signed [N-1:0] win [2];
  logic signed [N-1:0] bin0, bin1, left, center, right;
  logic accept, eval, is_peak, pop, full, push;
  logic [IW-1:0] fifo_idx [FIFO_DEPTH];
  logic signed [N-1:0] fifo_val [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  // win holds bins i-2 and i-1; together with binIn they form the 3-bin window for bin i-1
  assign accept = state == COLLECT && binWrite;
  assign eval = (accept && |cnt[IW-1:1]) || state != COLLECT;
  assign left = state == WRAP_FIRST ? win[1] : win[0];
  assign center = state == WRAP_FIRST ? bin0 : win[1];
  assign right = state == WRAP_LAST ? bin0 : state == WRAP_FIRST ? bin1 : binIn;
  assign eval_idx = state == WRAP_LAST ? last_bin : state == WRAP_FIRST ? '0 : cnt - 1'b1;
  assign is_peak = eval && center > left && center >= right && center > thresh;
  assign pop = peakValid && peakReady;
  assign full = count == depth;
  assign push = is_peak && (!full || pop);
  assign peakValid = count != '0;
  assign peakIdx = fifo_idx[rp];
  assign peakVal = fifo_val[rp];
  always_comb begin
    state_nx = state;
    state_nx = state == WRAP_LAST ? WRAP_FIRST : state == WRAP_FIRST ? COLLECT :
               accept && cnt == last_bin ? WRAP_LAST : COLLECT;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= COLLECT;
      cnt <= '0;
      win <= '{default: '0};
      bin0 <= '0;
      bin1 <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      fifo_idx <= '{default: '0};
      fifo_val <= '{default: '0};
      frameDone <= 1'b0;
      overflow <= 1'b0;
      dropErr <= 1'b0;
    end else begin
      state <= state_nx;
      frameDone <= state == WRAP_FIRST;
      dropErr <= dropErr | (binWrite && state != COLLECT);
      overflow <= overflow | (is_peak && full && !pop);
      cnt <= state == WRAP_FIRST ? '0 : accept ? cnt + 1'b1 : cnt;
      if (accept) begin
        win[0] <= win[1];
        win[1] <= binIn;
        if (cnt == '0) bin0 <= binIn;
        if (cnt == IW'(1)) bin1 <= binIn;
      end
      if (push) begin
        fifo_idx[wp] <= eval_idx;
        fifo_val[wp] <= center;
        wp <= wp == last_ptr ? '0 : wp + 1'b1;
      end
      if (pop) rp <= rp == last_ptr ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
`ifdef PEAK_FINDER_COUNT_EN
  // counts every detected peak, including ones the full FIFO dropped
  logic [$clog2(BINS+1)-1:0] found;
  always_ff @(posedge clk) begin
    if (!rst) begin
      found <= '0;
      peakCount <= '0;
    end else if (state == WRAP_FIRST) begin
      peakCount <= found + ($clog2(BINS+1))'(is_peak);
      found <= '0;
    end else if (is_peak) begin
      found <= found + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_peak_finder.sv
// tb_peak_finder: directed frame table, backpressure/reset sequences and random frames
// checked against a frame-level circular peak model and an expected-pop queue.
module tb_peak_finder;
  localparam int N = 16, BINS = 8, THRESH = 100, FD = 4;
  typedef logic [BINS-1:0][15:0] frame_t;
  typedef struct packed { logic [2:0] i; logic signed [15:0] v; } pk_t;
  typedef struct packed { frame_t b; logic [2:0] np; logic [1:0][2:0] ix; logic [1:0][15:0] v; } vec_t;

  logic clk = 0, rst, binWrite, peakReady, peakValid, frameDone, overflow, dropErr;
  logic signed [N-1:0] binIn, peakVal;
  logic [2:0] peakIdx;
`ifdef PEAK_FINDER_COUNT_EN
  logic [3:0] peakCount;
`endif

  peak_finder #(.N(N), .BINS(BINS), .THRESH(THRESH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .binIn(binIn), .binWrite(binWrite),
    .peakIdx(peakIdx), .peakVal(peakVal), .peakValid(peakValid), .peakReady(peakReady),
    .frameDone(frameDone), .overflow(overflow), .dropErr(dropErr)
`ifdef PEAK_FINDER_COUNT_EN
    , .peakCount(peakCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, fd_n = 0, pop_n = 0;
  pk_t exp_q[$];
  bit hold = 0, rnd = 0;
  logic [2:0] h_idx;
  logic signed [15:0] h_val;
  vec_t tbl[3];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // observes outputs at the negedge before the edge that consumes them
  task automatic mon();
    if (!rst) begin
      hold = 0;
      return;
    end
    if (hold) begin
      chk("hold_idx", peakIdx, h_idx);
      chk("hold_val", peakVal, h_val);
    end
    if (peakValid && peakReady) begin
      pop_n++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got idx %0d val %0d expected no peak", peakIdx, peakVal);
      end else begin
        checks--;
        chk("pop_idx", peakIdx, exp_q[0].i);
        chk("pop_val", peakVal, exp_q[0].v);
        void'(exp_q.pop_front());
      end
    end
    if (frameDone) fd_n++;
    hold = peakValid && !peakReady;
    h_idx = peakIdx;
    h_val = peakVal;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy();
    if (rnd) peakReady = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input frame_t f, input bit poke);
    for (int k = 0; k < BINS; k++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin
        binWrite = 0;
        rdy();
        cyc();
      end
      binWrite = 1;
      binIn = f[k];
      rdy();
      cyc();
    end
    binWrite = poke;
    binIn = 16'sd999;
    rdy();
    cyc();
    binWrite = 0;
    repeat (2) begin
      rdy();
      cyc();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (exp_q.size() != 0 || peakValid); i++) begin
      peakReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc();
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    rst = 0;
    binWrite = 0;
    repeat (n) cyc();
    rst = 1;
    exp_q.delete();
    hold = 0;
  endtask

  function automatic frame_t fr(input int a0, a1, a2, a3, a4, a5, a6, a7);
    fr[0] = 16'(a0); fr[1] = 16'(a1); fr[2] = 16'(a2); fr[3] = 16'(a3);
    fr[4] = 16'(a4); fr[5] = 16'(a5); fr[6] = 16'(a6); fr[7] = 16'(a7);
  endfunction

  function automatic vec_t mkv(input frame_t b, input int np, i0, v0, i1, v1);
    mkv.b = b; mkv.np = 3'(np);
    mkv.ix[0] = 3'(i0); mkv.v[0] = 16'(v0);
    mkv.ix[1] = 3'(i1); mkv.v[1] = 16'(v1);
  endfunction

  // circular peak rule over a whole frame, queued in emission order 1..BINS-1 then 0
  function automatic int model(input frame_t f);
    int n = 0, i;
    logic signed [15:0] c, l, r;
    for (int k = 1; k <= BINS; k++) begin
      i = k % BINS;
      c = f[i];
      l = f[(i + BINS - 1) % BINS];
      r = f[(i + 1) % BINS];
      if (c > l && c >= r && c > THRESH) begin
        exp_q.push_back('{i: 3'(i), v: c});
        n++;
      end
    end
    return n;
  endfunction

  initial begin
    frame_t f, bp;
    int n;
    rst = 0; binWrite = 0; binIn = 0; peakReady = 1;
    tbl[0] = mkv(fr(0, 50, 500, 200, 200, 900, 10, 0), 2, 2, 500, 5, 900);
    tbl[1] = mkv(fr(800, 10, 0, 0, 0, 0, 0, 300), 1, 0, 800, 0, 0);
    tbl[2] = mkv(fr(0, 200, 200, 0, -5, -300, -5, 0), 1, 1, 200, 0, 0);
    bp = fr(200, 0, 200, 0, 200, 0, 200, 0);

    repeat (5) cyc();
    chk("rst_valid", peakValid, 0);
    chk("rst_idx", peakIdx, 0);
    chk("rst_val", peakVal, 0);
    chk("rst_done", frameDone, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", dropErr, 0);
    rst = 1;

    for (int t = 0; t < 3; t++) begin
      for (int j = 0; j < int'(tbl[t].np); j++)
        exp_q.push_back('{i: tbl[t].ix[j], v: tbl[t].v[j]});
      fd_n = 0;
      send(tbl[t].b, 0);
      drain();
      chk("frame_done_n", fd_n, 1);
      chk("frame_ovf", overflow, 0);
`ifdef PEAK_FINDER_COUNT_EN
      chk("frame_count", peakCount, int'(tbl[t].np));
`endif
    end

    do_reset(1);
    peakReady = 0;
    send(bp, 0);
    chk("bp_full_valid", peakValid, 1);
    chk("bp_full_no_ovf", overflow, 0);
    chk("bp_no_drop", dropErr, 0);
    send(bp, 1);
    chk("bp_ovf", overflow, 1);
    chk("bp_drop", dropErr, 1);
`ifdef PEAK_FINDER_COUNT_EN
    chk("bp_count", peakCount, 4);
`endif
    for (int k = 2; k <= 8; k += 2) exp_q.push_back('{i: 3'(k % 8), v: 16'sd200});
    pop_n = 0;
    drain();
    chk("bp_pops", pop_n, 4);
    chk("bp_ovf_sticky", overflow, 1);
    do_reset(1);
    chk("rst_ovf_clr", overflow, 0);
    chk("rst_drop_clr", dropErr, 0);

    peakReady = 1;
    binWrite = 1;
    foreach (bp[k]) if (k < 3) begin
      binIn = 16'(k == 1 ? 0 : 300);
      cyc();
    end
    do_reset(1);
    exp_q.push_back('{i: 3'd2, v: 16'sd500});
    exp_q.push_back('{i: 3'd5, v: 16'sd900});
    fd_n = 0;
    send(tbl[0].b, 0);
    drain();
    chk("midrst_done_n", fd_n, 1);
    chk("midrst_ovf", overflow, 0);
`ifdef PEAK_FINDER_COUNT_EN
    chk("midrst_count", peakCount, 2);
`endif

    rnd = 1;
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < BINS; k++) f[k] = 16'(int'($urandom_range(0, 12)) * 100 - 300);
      n = model(f);
      fd_n = 0;
      send(f, 0);
      drain();
      chk("rnd_done_n", fd_n, 1);
      chk("rnd_ovf", overflow, 0);
`ifdef PEAK_FINDER_COUNT_EN
      chk("rnd_count", peakCount, n);
`else
      if (n > 4) chk("rnd_peaks_le_4", n, 4);
`endif
    end
    chk("rnd_drop", dropErr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
